// File: rtl/predictor_pkg.sv
// predictor_pkg: shared FSM encoding and predictor update record
package predictor_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      PAUSED = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic        taken;
   } upd_t;

   localparam int UPD_W = $bits(upd_t);

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count, no read bypass
module sync_fifo #(
   parameter int WIDTH = 33,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 1 << AW;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = count_q == (AW+1)'(DEPTH);
   assign empty   = count_q == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_q];
   assign count   = count_q;

   // pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // storage needs no reset: stale slots are never read while empty
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/predictor_update_ctrl.sv
// predictor_update_ctrl: buffers ROB branch outcomes and drains them to the predictor
module predictor_update_ctrl
   import predictor_pkg::*;
#(
   parameter int FIFO_WIDTH  = 3,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clockIn,
   input  logic                   resetIn,
   input  logic                   robValid,
   input  logic [31:0]            robAddr,
   input  logic                   robTaken,
   input  logic                   robPredicted,
   output logic                   robReady,
   input  logic                   pauseIn,
   input  logic                   clearStatsIn,
   output logic                   updateValid,
   output logic [31:0]            updateInstr,
   output logic                   taken,
   output logic [COUNT_WIDTH-1:0] branchCount,
   output logic [COUNT_WIDTH-1:0] mispredictCount,
   output logic                   idle
);

   state_e                 state_q, state_d;
   logic                   uv_q, taken_q;
   logic [31:0]            instr_q;
   logic [COUNT_WIDTH-1:0] bc_q, bc_d, mc_q, mc_d;
   logic                   push, pop, full, empty;
   logic [FIFO_WIDTH:0]    count, cnt_d;
   upd_t                   head, tail;

   assign tail     = '{addr: robAddr, taken: robTaken};
   assign robReady = !full;
   assign push     = robValid && robReady;
   assign pop      = !pauseIn && !empty;

   sync_fifo #(.WIDTH(UPD_W), .AW(FIFO_WIDTH)) u_fifo (
      .clk   (clockIn),
      .rst_n (resetIn),
      .push  (push),
      .pop   (pop),
      .din   (tail),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // next state follows post-edge occupancy and pause level; statistics count accepted pushes
   always_comb begin
      cnt_d   = count + (FIFO_WIDTH+1)'(push) - (FIFO_WIDTH+1)'(pop);
      state_d = (cnt_d == '0) ? IDLE : pauseIn ? PAUSED : DRAIN;
      bc_d    = (clearStatsIn ? '0 : bc_q) + COUNT_WIDTH'(push);
      mc_d    = (clearStatsIn ? '0 : mc_q) + COUNT_WIDTH'(push && (robTaken != robPredicted));
   end

   // FSM, registered update port and counters; reset drops any in-flight update
   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         state_q <= IDLE;
         uv_q    <= 1'b0;
         instr_q <= '0;
         taken_q <= 1'b0;
         bc_q    <= '0;
         mc_q    <= '0;
      end else begin
         state_q <= state_d;
         uv_q    <= pop;
         if (pop) begin
            instr_q <= head.addr;
            taken_q <= head.taken;
         end
         bc_q <= bc_d;
         mc_q <= mc_d;
      end
   end

   assign updateValid     = uv_q;
   assign updateInstr     = instr_q;
   assign taken           = taken_q;
   assign branchCount     = bc_q;
   assign mispredictCount = mc_q;
   assign idle            = (state_q == IDLE) && !uv_q;

endmodule

// File: tb/tb_predictor_update_ctrl.sv
// tb_predictor_update_ctrl: directed vector table plus multi-cycle corner sequences
module tb_predictor_update_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rob_valid = 1'b0, rob_taken = 1'b0, rob_pred = 1'b0;
   logic [31:0] rob_addr = '0;
   logic        pause = 1'b0, clr = 1'b0;
   logic        rob_ready, uv, ut, idl;
   logic [31:0] ui, bc, mc;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   predictor_update_ctrl dut (
      .clockIn         (clk),
      .resetIn         (rst_n),
      .robValid        (rob_valid),
      .robAddr         (rob_addr),
      .robTaken        (rob_taken),
      .robPredicted    (rob_pred),
      .robReady        (rob_ready),
      .pauseIn         (pause),
      .clearStatsIn    (clr),
      .updateValid     (uv),
      .updateInstr     (ui),
      .taken           (ut),
      .branchCount     (bc),
      .mispredictCount (mc),
      .idle            (idl)
   );

   typedef struct {
      logic        v;
      logic [31:0] a;
      logic        t, p, ps, cl;
      logic        rdy, uv;
      logic [31:0] ui;
      logic        ut;
      logic [31:0] bc, mc;
      logic        idl;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " robReady"}, 32'(rob_ready), 32'd1);
      chk({tag, " updateValid"}, 32'(uv), 32'd0);
      chk({tag, " updateInstr"}, ui, 32'd0);
      chk({tag, " taken"}, 32'(ut), 32'd0);
      chk({tag, " branchCount"}, bc, 32'd0);
      chk({tag, " mispredictCount"}, mc, 32'd0);
      chk({tag, " idle"}, 32'(idl), 32'd1);
   endtask

   initial begin
      //          v  addr          t  p  ps cl  rdy uv ui            ut bc  mc  idle
      vecs[0]  = '{1, 32'h0000_1004, 1, 0, 0, 0,  1, 0, 32'h0,        0, 1,  1,  0};
      vecs[1]  = '{0, 32'h0,         0, 0, 0, 0,  1, 1, 32'h0000_1004, 1, 1,  1,  0};
      vecs[2]  = '{0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h0000_1004, 1, 1,  1,  1};
      vecs[3]  = '{1, 32'h0000_2000, 0, 0, 0, 0,  1, 0, 32'h0000_1004, 1, 2,  1,  0};
      vecs[4]  = '{1, 32'h0000_3000, 1, 1, 0, 0,  1, 1, 32'h0000_2000, 0, 3,  1,  0};
      vecs[5]  = '{1, 32'h0000_4000, 0, 1, 0, 1,  1, 1, 32'h0000_3000, 1, 1,  1,  0};
      vecs[6]  = '{0, 32'h0,         0, 0, 0, 1,  1, 1, 32'h0000_4000, 0, 0,  0,  0};
      vecs[7]  = '{0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h0000_4000, 0, 0,  0,  1};
      vecs[8]  = '{1, 32'h0000_5000, 1, 1, 1, 0,  1, 0, 32'h0000_4000, 0, 1,  0,  0};
      vecs[9]  = '{0, 32'h0,         0, 0, 1, 0,  1, 0, 32'h0000_4000, 0, 1,  0,  0};
      vecs[10] = '{0, 32'h0,         0, 0, 0, 0,  1, 1, 32'h0000_5000, 1, 1,  0,  0};
      vecs[11] = '{0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h0000_5000, 1, 1,  0,  1};

      #12;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         rob_valid = vecs[i].v;
         rob_addr  = vecs[i].a;
         rob_taken = vecs[i].t;
         rob_pred  = vecs[i].p;
         pause     = vecs[i].ps;
         clr       = vecs[i].cl;
         tick();
         chk($sformatf("v%0d robReady", i), 32'(rob_ready), 32'(vecs[i].rdy));
         chk($sformatf("v%0d updateValid", i), 32'(uv), 32'(vecs[i].uv));
         chk($sformatf("v%0d updateInstr", i), ui, vecs[i].ui);
         chk($sformatf("v%0d taken", i), 32'(ut), 32'(vecs[i].ut));
         chk($sformatf("v%0d branchCount", i), bc, vecs[i].bc);
         chk($sformatf("v%0d mispredictCount", i), mc, vecs[i].mc);
         chk($sformatf("v%0d idle", i), 32'(idl), 32'(vecs[i].idl));
      end
      rob_valid = 1'b0;
      clr = 1'b0;

      // paused burst of 10 offers: only 8 accepted, the rest held by the ROB
      begin
         int acc = 0;
         pause = 1'b1;
         rob_taken = 1'b0;
         rob_pred = 1'b0;
         for (int i = 0; i < 10; i++) begin
            rob_valid = 1'b1;
            rob_addr = 32'h100 + 32'(acc);
            if (rob_ready) acc++;
            tick();
            chk($sformatf("burst%0d updateValid", i), 32'(uv), 32'd0);
            chk($sformatf("burst%0d robReady", i), 32'(rob_ready), (acc >= 8) ? 32'd0 : 32'd1);
         end
         chk("burst accepted", 32'(acc), 32'd8);
         chk("burst branchCount", bc, 32'd9);
      end

      // full FIFO with a push and a pop offered together: push refused, count 8 -> 7
      rob_addr = 32'h0000_0DEA;
      pause = 1'b0;
      tick();
      chk("fullpop updateValid", 32'(uv), 32'd1);
      chk("fullpop updateInstr", ui, 32'h100);
      chk("fullpop robReady", 32'(rob_ready), 32'd1);
      chk("fullpop branchCount", bc, 32'd9);
      rob_valid = 1'b0;
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("drain%0d updateValid", k), 32'(uv), 32'd1);
         chk($sformatf("drain%0d updateInstr", k), ui, 32'h100 + 32'(k));
      end
      tick();
      chk("drained updateValid", 32'(uv), 32'd0);
      chk("drained idle", 32'(idl), 32'd1);

      // sustained push+pop for 20 cycles: occupancy stays at 1, order preserved across wraps
      for (int i = 0; i < 20; i++) begin
         rob_valid = 1'b1;
         rob_addr = 32'h7000 + 32'(i);
         rob_taken = i[0];
         tick();
         chk($sformatf("stream%0d robReady", i), 32'(rob_ready), 32'd1);
         chk($sformatf("stream%0d idle", i), 32'(idl), 32'd0);
         if (i > 0) begin
            chk($sformatf("stream%0d updateValid", i), 32'(uv), 32'd1);
            chk($sformatf("stream%0d updateInstr", i), ui, 32'h7000 + 32'(i - 1));
         end
      end
      rob_valid = 1'b0;
      tick();
      chk("stream tail updateInstr", ui, 32'h7000 + 32'd19);
      chk("stream tail taken", 32'(ut), 32'd1);
      tick();
      chk("stream end updateValid", 32'(uv), 32'd0);
      chk("stream end branchCount", bc, 32'd29);

      // clear coinciding with a mispredicted push counts that push
      rob_valid = 1'b1;
      rob_addr = 32'h8000;
      rob_taken = 1'b1;
      rob_pred = 1'b0;
      clr = 1'b1;
      tick();
      chk("clear branchCount", bc, 32'd1);
      chk("clear mispredictCount", mc, 32'd1);
      rob_valid = 1'b0;
      clr = 1'b0;
      tick();
      tick();

      // reset mid-operation with entries queued and an update in flight
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rob_valid = 1'b1;
         rob_addr = 32'h9000 + 32'(i);
         tick();
      end
      rob_valid = 1'b0;
      pause = 1'b0;
      tick();
      chk("prereset updateValid", 32'(uv), 32'd1);
      chk("prereset updateInstr", ui, 32'h9000);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("postreset%0d updateValid", i), 32'(uv), 32'd0);
         chk($sformatf("postreset%0d idle", i), 32'(idl), 32'd1);
         chk($sformatf("postreset%0d updateInstr", i), ui, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
